// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//
// Purpose:
//   Parameterised up/down counter with a programmable inclusive upper bound
//   (limit), selectable wrap or saturate behaviour at the bounds, a
//   synchronous load and a registered terminal-count pulse. The count
//   direction comes from a GPIO pad asynchronous to clk, so it is passed
//   through a multi-flop synchroniser before it steers counting.
//
// Parameters:
//   WIDTH        counter / output bit width (2..32)
//   SYNC_STAGES  synchroniser depth on up_down (2..3)
//
// Ports:
//   clk        in   1      single clock, rising-edge active
//   reset_n    in   1      asynchronous active-low reset
//   up_down    in   1      raw count direction from pad (1 = up, 0 = down)
//   en         in   1      count enable, one step per cycle while high
//   load       in   1      synchronous load strobe (beats en)
//   load_val   in   WIDTH  load value, clamped to limit
//   limit      in   WIDTH  inclusive upper bound, quasi-static
//   sat_mode   in   1      0 = wrap at bounds, 1 = saturate at bounds
//   counter    out  WIDTH  registered count value
//   io_oeb     out  WIDTH  pad output-enable (active-low), tied to zero
//   tc         out  1      registered terminal-count pulse
//   dir        out  1      synchronised direction currently in effect
// -----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             up_down,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] io_oeb,
    output logic             tc,
    output logic             dir
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [SYNC_STAGES-1:0] dir_sync;
    logic [1:0]             rst_sync;
    logic                   run;
    logic [WIDTH-1:0]       next_count;
    logic                   next_tc;

    // The pads are always driven by this block.
    assign io_oeb = '0;

    // Reset release is resynchronised so the counter never takes a step on
    // an edge that is racing the reset deassertion; assertion stays async.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Direction synchroniser: only the last stage is allowed to steer counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_sync <= '0;
        end else begin
            dir_sync <= {dir_sync[SYNC_STAGES-2:0], up_down};
        end
    end

    assign dir = dir_sync[SYNC_STAGES-1];

    // Next-state decode: load beats en beats hold. All compares are WIDTH-bit
    // unsigned; the increment is only taken when counter < limit and the
    // decrement only when counter > 0, so neither can overflow.
    always_comb begin
        next_count = counter;
        next_tc    = 1'b0;
        if (load) begin
            next_count = (load_val <= limit) ? load_val : limit;
        end else if (en) begin
            if (dir) begin
                if (counter < limit) begin
                    next_count = counter + ONE;
                end else begin
                    next_count = sat_mode ? limit : ZERO;
                    next_tc    = 1'b1;
                end
            end else begin
                if (counter > limit) begin
                    // limit was lowered below the current count at runtime
                    next_count = limit;
                end else if (counter != ZERO) begin
                    next_count = counter - ONE;
                end else begin
                    next_count = sat_mode ? ZERO : limit;
                    next_tc    = 1'b1;
                end
            end
        end
    end

    // Count register; held (with tc low) until the reset synchroniser
    // reports that reset has been cleanly released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
            tc      <= 1'b0;
        end else if (run) begin
            counter <= next_count;
            tc      <= next_tc;
        end else begin
            tc      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
//
// Purpose:
//   Self-checking bench for updown_counter_param (WIDTH=4, SYNC_STAGES=2).
//   Hand-written sequences cover reset, first-step timing, full-range wrap,
//   saturation with a direction change and an asynchronous mid-count reset.
//   A vector table covers load clamping, limit changes and bound cases, and
//   a randomized phase is checked against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_updown_counter_param;

    localparam int W  = 4;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         up_down;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] limit;
    logic         sat_mode;
    logic [W-1:0] counter;
    logic [W-1:0] io_oeb;
    logic         tc;
    logic         dir;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_cnt;
    bit m_tc;
    bit m_pipe[$];
    int m_rel;

    typedef struct {
        logic ld;
        logic en;
        logic up;
        int   lv;
        int   lim;
        logic sat;
        int   exp_cnt;
        logic exp_tc;
        logic exp_dir;
    } vec_t;

    vec_t vq[$];

    updown_counter_param #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .up_down  (up_down),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .sat_mode (sat_mode),
        .counter  (counter),
        .io_oeb   (io_oeb),
        .tc       (tc),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic e, input logic ud,
                                 input int lv, input int lim, input logic sat);
        load     = ld;
        en       = e;
        up_down  = ud;
        load_val = W'(lv);
        limit    = W'(lim);
        sat_mode = sat;
    endtask

    task automatic modelReset();
        m_cnt = 0;
        m_tc  = 0;
        m_rel = 0;
        m_pipe.delete();
        for (int i = 0; i < SS; i++) m_pipe.push_back(1'b0);
    endtask

    // Counting rules written directly from the block's behaviour description:
    // the direction in effect is up_down as it was SS edges earlier, and the
    // first step after reset release happens on the third edge.
    task automatic modelStep();
        bit d;
        int lim;
        int lv;
        int c;
        d   = m_pipe[0];
        lim = int'(limit);
        lv  = int'(load_val);
        c   = m_cnt;
        m_tc = 0;
        if (m_rel >= 2) begin
            if (load) begin
                m_cnt = (lv < lim) ? lv : lim;
            end else if (en) begin
                if (d) begin
                    if (c < lim) m_cnt = c + 1;
                    else begin
                        m_cnt = sat_mode ? lim : 0;
                        m_tc  = 1;
                    end
                end else begin
                    if (c > lim) m_cnt = lim;
                    else if (c > 0) m_cnt = c - 1;
                    else begin
                        m_cnt = sat_mode ? 0 : lim;
                        m_tc  = 1;
                    end
                end
            end
        end
        m_rel++;
        void'(m_pipe.pop_front());
        m_pipe.push_back(up_down);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic addVec(input logic ld, input logic e, input logic ud, input int lv,
                          input int lim, input logic sat, input int ec,
                          input logic et, input logic ed);
        vec_t v;
        v.ld = ld; v.en = e; v.up = ud; v.lv = lv; v.lim = lim; v.sat = sat;
        v.exp_cnt = ec; v.exp_tc = et; v.exp_dir = ed;
        vq.push_back(v);
    endtask

    initial begin
        int exp_c;
        // ---------------- reset state ----------------
        reset_n = 1'b0;
        applyStimulus(0, 1, 1, 0, 15, 0);
        modelReset();
        #12;
        checkOutput("reset_counter", int'(counter), 0);
        checkOutput("reset_tc", int'(tc), 0);
        checkOutput("reset_dir", int'(dir), 0);
        checkOutput("reset_oeb", int'(io_oeb), 0);

        // ---------------- first step after release ----------------
        reset_n = 1'b1;
        tick();
        checkOutput("rel_edge1_counter", int'(counter), 0);
        checkOutput("rel_edge1_dir", int'(dir), 0);
        tick();
        checkOutput("rel_edge2_counter", int'(counter), 0);
        checkOutput("rel_edge2_dir", int'(dir), 1);
        tick();
        checkOutput("rel_edge3_counter", int'(counter), 1);

        // ---------------- full-range wrap, limit=15 ----------------
        for (int k = 2; k <= 20; k++) begin
            tick();
            exp_c = k % 16;
            checkOutput("wrap15_counter", int'(counter), exp_c);
            checkOutput("wrap15_tc", int'(tc), (exp_c == 0) ? 1 : 0);
        end

        // ---------------- saturate at 9, then turn around ----------------
        applyStimulus(1, 1, 1, 0, 9, 1);
        tick();
        checkOutput("sat9_load0", int'(counter), 0);
        applyStimulus(0, 1, 1, 0, 9, 1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            checkOutput("sat9_counter", int'(counter), (k < 9) ? k : 9);
            checkOutput("sat9_tc", int'(tc), (k >= 10) ? 1 : 0);
        end
        applyStimulus(0, 1, 0, 0, 9, 1);
        tick();
        checkOutput("turn_e1_counter", int'(counter), 9);
        checkOutput("turn_e1_tc", int'(tc), 1);
        checkOutput("turn_e1_dir", int'(dir), 1);
        tick();
        checkOutput("turn_e2_counter", int'(counter), 9);
        checkOutput("turn_e2_dir", int'(dir), 0);
        tick();
        checkOutput("turn_e3_counter", int'(counter), 8);
        checkOutput("turn_e3_tc", int'(tc), 0);
        tick();
        checkOutput("turn_e4_counter", int'(counter), 7);

        // ---------------- asynchronous reset mid-count ----------------
        applyStimulus(1, 1, 1, 11, 15, 0);
        tick();
        tick();
        tick();
        checkOutput("pre_rst_counter", int'(counter), 11);
        applyStimulus(0, 1, 1, 0, 15, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_counter", int'(counter), 0);
        checkOutput("midrst_tc", int'(tc), 0);
        checkOutput("midrst_dir", int'(dir), 0);
        checkOutput("midrst_oeb", int'(io_oeb), 0);
        @(posedge clk);
        #1;
        checkOutput("inrst_counter", int'(counter), 0);
        checkOutput("inrst_tc", int'(tc), 0);
        #2;
        reset_n = 1'b1;
        modelReset();
        applyStimulus(0, 0, 1, 0, 15, 0);
        repeat (4) tick();
        checkOutput("settle_counter", int'(counter), 0);
        checkOutput("settle_dir", int'(dir), 1);

        // ---------------- vector table ----------------
        //     ld en up lv lim sat  cnt tc dir
        addVec(1, 1, 1, 12, 5, 0,   5, 0, 1);
        addVec(0, 1, 1, 0,  5, 0,   0, 1, 1);
        addVec(0, 1, 1, 0,  5, 0,   1, 0, 1);
        addVec(0, 0, 1, 0,  5, 0,   1, 0, 1);
        addVec(1, 0, 1, 3,  5, 0,   3, 0, 1);
        addVec(0, 1, 1, 0,  4, 1,   4, 0, 1);
        addVec(0, 1, 1, 0,  4, 1,   4, 1, 1);
        addVec(0, 1, 1, 0,  4, 1,   4, 1, 1);
        addVec(0, 1, 1, 0,  2, 1,   2, 1, 1);
        addVec(0, 1, 1, 0,  0, 0,   0, 1, 1);
        addVec(0, 1, 1, 0,  0, 0,   0, 1, 1);
        addVec(1, 0, 1, 15, 15, 0,  15, 0, 1);
        addVec(0, 1, 1, 0,  15, 0,  0, 1, 1);
        addVec(1, 0, 1, 12, 15, 0,  12, 0, 1);
        addVec(0, 1, 1, 0,  7, 0,   0, 1, 1);
        addVec(1, 0, 1, 12, 15, 0,  12, 0, 1);
        addVec(0, 1, 1, 0,  7, 1,   7, 1, 1);
        addVec(1, 0, 0, 12, 15, 0,  12, 0, 1);
        addVec(0, 1, 0, 0,  7, 0,   0, 1, 0);
        addVec(1, 0, 0, 12, 15, 0,  12, 0, 0);
        addVec(0, 1, 0, 0,  7, 0,   7, 0, 0);
        addVec(0, 1, 0, 0,  7, 0,   6, 0, 0);
        addVec(1, 0, 0, 0,  5, 0,   0, 0, 0);
        addVec(0, 1, 0, 0,  5, 0,   5, 1, 0);
        addVec(1, 0, 0, 0,  5, 1,   0, 0, 0);
        addVec(0, 1, 0, 0,  5, 1,   0, 1, 0);
        addVec(0, 1, 0, 0,  5, 1,   0, 1, 0);
        addVec(0, 1, 1, 0,  5, 0,   5, 1, 0);
        addVec(0, 1, 1, 0,  5, 0,   4, 0, 1);
        addVec(0, 1, 1, 0,  5, 0,   5, 0, 1);
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].ld, vq[i].en, vq[i].up, vq[i].lv, vq[i].lim, vq[i].sat);
            tick();
            checkOutput($sformatf("vec%0d_counter", i), int'(counter), vq[i].exp_cnt);
            checkOutput($sformatf("vec%0d_tc", i), int'(tc), int'(vq[i].exp_tc));
            checkOutput($sformatf("vec%0d_dir", i), int'(dir), int'(vq[i].exp_dir));
        end

        // ---------------- randomized phase against the model ----------------
        begin
            int   lim_r;
            logic sat_r;
            logic ud_r;
            lim_r = 11;
            sat_r = 1'b0;
            ud_r  = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 31) == 0) lim_r = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 15));
                if ($urandom_range(0, 15) == 0) sat_r = ~sat_r;
                if ($urandom_range(0, 5) == 0) ud_r = ~ud_r;
                applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), ud_r,
                              int'($urandom_range(0, 15)), lim_r, sat_r);
                tick();
                checkOutput("rand_counter", int'(counter), m_cnt);
                checkOutput("rand_tc", int'(tc), int'(m_tc));
                checkOutput("rand_dir", int'(dir), int'(m_pipe[0]));
            end
            checkOutput("rand_oeb", int'(io_oeb), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
